// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings for the MIPS writeback stage.
//   wsrc_e      : result-source select carried on m_wsrc (values 5-7 select zero)
//   ld_e        : load-extension op carried on m_load_op (unlisted values act as word)
//   PC_LINK_OFS : link-address offset added to the PC for the pc+8 source
package wb_pkg;

  typedef enum logic [2:0] {
    WSRC_ALU = 3'd0,
    WSRC_MEM = 3'd1,
    WSRC_IMM = 3'd2,
    WSRC_PC8 = 3'd3,
    WSRC_MDU = 3'd4
  } wsrc_e;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ld_e;

  localparam int unsigned PC_LINK_OFS = 8;

endpackage

// File: rtl/wb_load_ext.sv
// wb_load_ext: combinational sub-word load extension.
//   load_op : ld_e encoding (word / lb / lbu / lh / lhu, others word)
//   boff    : byte offset of the access; halfword ops ignore boff[0]
//   raw     : aligned memory word
//   ext     : selected lane, sign- or zero-extended to XLEN
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]                 load_op,
  input  logic [$clog2(XLEN/8)-1:0]  boff,
  input  logic [XLEN-1:0]            raw,
  output logic [XLEN-1:0]            ext
);

  localparam int unsigned BW = $clog2(XLEN/8);

  logic [XLEN-1:0] w_bsh;
  logic [XLEN-1:0] w_hsh;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  // Shift the selected lane down to bit 0; halfword lane index is boff>>1.
  assign w_bsh  = raw >> {boff, 3'b000};
  assign w_hsh  = raw >> {boff[BW-1:1], 4'b0000};
  assign w_byte = w_bsh[7:0];
  assign w_half = w_hsh[15:0];

  always_comb begin
    ext = raw;
    case (load_op)
      LD_B:    ext = {{(XLEN-8){w_byte[7]}}, w_byte};
      LD_BU:   ext = {{(XLEN-8){1'b0}}, w_byte};
      LD_H:    ext = {{(XLEN-16){w_half[15]}}, w_half};
      LD_HU:   ext = {{(XLEN-16){1'b0}}, w_half};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// wb_unit: writeback stage of the five-stage MIPS pipeline.
// Owns the M/W register (stall/flush), load extension, result-source select,
// destination resolution (incl. compare-selected destination) and drives the
// register-file write port, which doubles as the W-stage forwarding bus (Tnew=0).
// Ports:
//   clk, reset (sync, active-low), w_stall, w_flush
//   m_valid, m_pc, m_alu, m_mdu, m_imm, m_mem, m_cmp, m_wsrc, m_wen,
//   m_wdst, m_wdst_alt, m_cond_dst, m_load_op, m_boff   : M-stage inputs
//   rf_we, rf_waddr, rf_wdata                           : register-file write port
//   w_pc, w_valid                                       : W-stage status
//   retire_cnt                                          : only with WB_RETIRE_CNT_EN
// Optional feature macro: WB_RETIRE_CNT_EN (retired-instruction counter).
module wb_unit
  import wb_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter int unsigned      RAW      = 5,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_3000,
  parameter int unsigned      RCNT_W   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       w_stall,
  input  logic                       w_flush,
  input  logic                       m_valid,
  input  logic [XLEN-1:0]            m_pc,
  input  logic [XLEN-1:0]            m_alu,
  input  logic [XLEN-1:0]            m_mdu,
  input  logic [XLEN-1:0]            m_imm,
  input  logic [XLEN-1:0]            m_mem,
  input  logic [XLEN-1:0]            m_cmp,
  input  logic [2:0]                 m_wsrc,
  input  logic                       m_wen,
  input  logic [RAW-1:0]             m_wdst,
  input  logic [RAW-1:0]             m_wdst_alt,
  input  logic                       m_cond_dst,
  input  logic [2:0]                 m_load_op,
  input  logic [$clog2(XLEN/8)-1:0]  m_boff,
  output logic                       rf_we,
  output logic [RAW-1:0]             rf_waddr,
  output logic [XLEN-1:0]            rf_wdata,
  output logic [XLEN-1:0]            w_pc,
  output logic                       w_valid
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [RCNT_W-1:0]          retire_cnt
`endif
);

  localparam int unsigned BW = $clog2(XLEN/8);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_alu;
  logic [XLEN-1:0] r_mdu;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_mem;
  logic [XLEN-1:0] r_cmp;
  logic [2:0]      r_wsrc;
  logic            r_wen;
  logic [RAW-1:0]  r_wdst;
  logic [RAW-1:0]  r_wdst_alt;
  logic            r_cond_dst;
  logic [2:0]      r_load_op;
  logic [BW-1:0]   r_boff;

  logic [XLEN-1:0] w_ext;
  logic [XLEN-1:0] w_res;
  logic [RAW-1:0]  w_dst;
  logic            w_we;

  // Flush only kills valid/wen; payload fields are left as they were.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid    <= 1'b0;
      r_pc       <= RESET_PC;
      r_alu      <= '0;
      r_mdu      <= '0;
      r_imm      <= '0;
      r_mem      <= '0;
      r_cmp      <= '0;
      r_wsrc     <= WSRC_ALU;
      r_wen      <= 1'b0;
      r_wdst     <= '0;
      r_wdst_alt <= '0;
      r_cond_dst <= 1'b0;
      r_load_op  <= LD_W;
      r_boff     <= '0;
    end else if (w_flush) begin
      r_valid <= 1'b0;
      r_wen   <= 1'b0;
    end else if (!w_stall) begin
      r_valid    <= m_valid;
      r_pc       <= m_pc;
      r_alu      <= m_alu;
      r_mdu      <= m_mdu;
      r_imm      <= m_imm;
      r_mem      <= m_mem;
      r_cmp      <= m_cmp;
      r_wsrc     <= m_wsrc;
      r_wen      <= m_wen;
      r_wdst     <= m_wdst;
      r_wdst_alt <= m_wdst_alt;
      r_cond_dst <= m_cond_dst;
      r_load_op  <= m_load_op;
      r_boff     <= m_boff;
    end
  end

  wb_load_ext #(.XLEN(XLEN)) u_load_ext (
    .load_op (r_load_op),
    .boff    (r_boff),
    .raw     (r_mem),
    .ext     (w_ext)
  );

  always_comb begin
    w_res = '0;
    case (r_wsrc)
      WSRC_ALU: w_res = r_alu;
      WSRC_MEM: w_res = w_ext;
      WSRC_IMM: w_res = r_imm;
      WSRC_PC8: w_res = r_pc + XLEN'(PC_LINK_OFS);
      WSRC_MDU: w_res = r_mdu;
      default:  w_res = '0;
    endcase
  end

  // Compare-selected destination uses the extended load value, full width signed.
  always_comb begin
    w_dst = r_wdst;
    if (r_cond_dst && ($signed(r_cmp) < $signed(w_ext)))
      w_dst = r_wdst_alt;
  end

  assign w_we = r_valid & r_wen & (w_dst != '0);

  always_comb begin
    rf_we    = w_we;
    rf_waddr = w_we ? w_dst : '0;
    rf_wdata = w_res;
  end

  assign w_pc    = r_pc;
  assign w_valid = r_valid;

`ifdef WB_RETIRE_CNT_EN
  logic [RCNT_W-1:0] r_retire_cnt;

  // W leaves the stage on any unstalled edge, whether replaced by M or a bubble.
  always_ff @(posedge clk) begin
    if (!reset)
      r_retire_cnt <= '0;
    else if (r_valid && !w_stall)
      r_retire_cnt <= r_retire_cnt + 1'b1;
  end

  assign retire_cnt = r_retire_cnt;
`else
  logic [RCNT_W-1:0] w_unused_rcnt;
  assign w_unused_rcnt = '0;
`endif

endmodule

// File: tb/tb_wb_unit.sv
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        reset, w_stall, w_flush, m_valid;
  logic [31:0] m_pc, m_alu, m_mdu, m_imm, m_mem, m_cmp;
  logic [2:0]  m_wsrc, m_load_op;
  logic        m_wen, m_cond_dst;
  logic [4:0]  m_wdst, m_wdst_alt;
  logic [1:0]  m_boff;

  logic        rf_we, rf_we4;
  logic [4:0]  rf_waddr, rf_waddr4;
  logic [31:0] rf_wdata, rf_wdata4, w_pc, w_pc4;
  logic        w_valid, w_valid4;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
  logic [3:0]  retire_cnt4;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  wb_unit #(.XLEN(32), .RAW(5), .RESET_PC(32'h0000_3000), .RCNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .w_stall(w_stall), .w_flush(w_flush),
    .m_valid(m_valid), .m_pc(m_pc), .m_alu(m_alu), .m_mdu(m_mdu),
    .m_imm(m_imm), .m_mem(m_mem), .m_cmp(m_cmp), .m_wsrc(m_wsrc),
    .m_wen(m_wen), .m_wdst(m_wdst), .m_wdst_alt(m_wdst_alt),
    .m_cond_dst(m_cond_dst), .m_load_op(m_load_op), .m_boff(m_boff),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .w_pc(w_pc), .w_valid(w_valid)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  wb_unit #(.XLEN(32), .RAW(5), .RESET_PC(32'h0000_3000), .RCNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .w_stall(w_stall), .w_flush(w_flush),
    .m_valid(m_valid), .m_pc(m_pc), .m_alu(m_alu), .m_mdu(m_mdu),
    .m_imm(m_imm), .m_mem(m_mem), .m_cmp(m_cmp), .m_wsrc(m_wsrc),
    .m_wen(m_wen), .m_wdst(m_wdst), .m_wdst_alt(m_wdst_alt),
    .m_cond_dst(m_cond_dst), .m_load_op(m_load_op), .m_boff(m_boff),
    .rf_we(rf_we4), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4),
    .w_pc(w_pc4), .w_valid(w_valid4)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt4)
`endif
  );

  // Reference model: contents of the W stage as plain variables.
  logic        q_valid = 1'b0;
  logic [31:0] q_pc = 32'h0000_3000, q_alu = '0, q_mdu = '0, q_imm = '0, q_mem = '0, q_cmp = '0;
  logic [2:0]  q_wsrc = '0, q_load_op = '0;
  logic        q_wen = 1'b0, q_cond = 1'b0;
  logic [4:0]  q_wdst = '0, q_alt = '0;
  logic [1:0]  q_boff = '0;
  longint unsigned q_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [2:0] op, input logic [1:0] boff,
                                          input logic [31:0] raw);
    int unsigned b, h;
    b = (raw >> (8 * int'(boff))) % 256;
    h = (raw >> (16 * (int'(boff) / 2))) % 65536;
    case (op)
      3'd1:    return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
      3'd2:    return 32'(b);
      3'd3:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
      3'd4:    return 32'(h);
      default: return raw;
    endcase
  endfunction

  function automatic logic [31:0] ref_data();
    case (q_wsrc)
      3'd0:    return q_alu;
      3'd1:    return ref_ext(q_load_op, q_boff, q_mem);
      3'd2:    return q_imm;
      3'd3:    return q_pc + 32'd8;
      3'd4:    return q_mdu;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [4:0] ref_dst();
    longint signed c, e;
    c = longint'($signed(q_cmp));
    e = longint'($signed(ref_ext(q_load_op, q_boff, q_mem)));
    return (q_cond && c < e) ? q_alt : q_wdst;
  endfunction

  // One clock edge: update the model from the current inputs, then settle.
  task automatic step();
    @(posedge clk);
    if (reset && q_valid && !w_stall) q_cnt++;
    if (!reset) begin
      q_valid = 0; q_pc = 32'h0000_3000; q_alu = 0; q_mdu = 0; q_imm = 0; q_mem = 0;
      q_cmp = 0; q_wsrc = 0; q_wen = 0; q_wdst = 0; q_alt = 0; q_cond = 0;
      q_load_op = 0; q_boff = 0; q_cnt = 0;
    end else if (w_flush) begin
      q_valid = 0; q_wen = 0;
    end else if (!w_stall) begin
      q_valid = m_valid; q_pc = m_pc; q_alu = m_alu; q_mdu = m_mdu; q_imm = m_imm;
      q_mem = m_mem; q_cmp = m_cmp; q_wsrc = m_wsrc; q_wen = m_wen; q_wdst = m_wdst;
      q_alt = m_wdst_alt; q_cond = m_cond_dst; q_load_op = m_load_op; q_boff = m_boff;
    end
    #1;
  endtask

  task automatic check_model();
    logic       we;
    logic [4:0] d;
    d  = ref_dst();
    we = q_valid && q_wen && (d != 5'd0);
    check("m_we", 64'(rf_we), 64'(we));
    check("m_waddr", 64'(rf_waddr), 64'(we ? d : 5'd0));
    check("m_valid", 64'(w_valid), 64'(q_valid));
    check("m_pc", 64'(w_pc), 64'(q_pc));
    if (q_valid) check("m_wdata", 64'(rf_wdata), 64'(ref_data()));
`ifdef WB_RETIRE_CNT_EN
    check("m_cnt", 64'(retire_cnt), q_cnt % 64'h1_0000_0000);
    check("m_cnt4", 64'(retire_cnt4), q_cnt % 16);
`endif
  endtask

  task automatic instr(input logic [2:0] wsrc, input logic [4:0] dst, input logic [2:0] op,
                       input logic [1:0] boff);
    m_valid = 1; m_wen = 1; m_wsrc = wsrc; m_wdst = dst; m_load_op = op; m_boff = boff;
    m_cond_dst = 0;
  endtask

  logic [31:0] hold_d;
  logic [4:0]  hold_a;
  logic        hold_w;

  initial begin
    reset = 0; w_stall = 0; w_flush = 0; m_valid = 1; m_wen = 1; m_pc = 32'h100;
    m_alu = 32'h1234; m_mdu = 0; m_imm = 0; m_mem = 0; m_cmp = 0; m_wsrc = 0;
    m_wdst = 5'd8; m_wdst_alt = 0; m_cond_dst = 0; m_load_op = 0; m_boff = 0;

    step(); step();
    check("rst_we", 64'(rf_we), 64'd0);
    check("rst_waddr", 64'(rf_waddr), 64'd0);
    check("rst_wdata", 64'(rf_wdata), 64'd0);
    check("rst_valid", 64'(w_valid), 64'd0);
    check("rst_pc", 64'(w_pc), 64'h3000);
`ifdef WB_RETIRE_CNT_EN
    check("rst_cnt", 64'(retire_cnt), 64'd0);
`endif
    reset = 1;

    m_mem = 32'h8899_AABB;
    instr(3'd1, 5'd8, 3'd1, 2'd1); step();
    check("lb", 64'(rf_wdata), 64'hFFFF_FFAA);
    check("lb_addr", 64'(rf_waddr), 64'd8);
    check("lb_we", 64'(rf_we), 64'd1);
    instr(3'd1, 5'd8, 3'd2, 2'd3); step();
    check("lbu", 64'(rf_wdata), 64'h0000_0088);
    instr(3'd1, 5'd8, 3'd3, 2'd3); step();
    check("lh", 64'(rf_wdata), 64'hFFFF_8899);
    instr(3'd1, 5'd8, 3'd4, 2'd0); step();
    check("lhu", 64'(rf_wdata), 64'h0000_AABB);
    instr(3'd1, 5'd8, 3'd0, 2'd2); step();
    check("lw", 64'(rf_wdata), 64'h8899_AABB);

    instr(3'd0, 5'd4, 3'd0, 2'd0);
    m_wdst_alt = 5'd5; m_mem = 32'h0000_0001; m_cond_dst = 1; m_cmp = 32'hFFFF_FFFF;
    step();
    check("cond_alt", 64'(rf_waddr), 64'd5);
    m_cmp = 32'h0000_0002; step();
    check("cond_pri", 64'(rf_waddr), 64'd4);
    m_cond_dst = 0;

    instr(3'd3, 5'd31, 3'd0, 2'd0); m_pc = 32'h0000_3010; step();
    check("link_data", 64'(rf_wdata), 64'h0000_3018);
    check("link_addr", 64'(rf_waddr), 64'd31);
    check("link_pc", 64'(w_pc), 64'h0000_3010);
    m_wdst = 5'd0; step();
    check("r0_we", 64'(rf_we), 64'd0);
    check("r0_addr", 64'(rf_waddr), 64'd0);

    instr(3'd0, 5'd9, 3'd0, 2'd0); m_alu = 32'hCAFE_0001; step();
    hold_d = rf_wdata; hold_a = rf_waddr; hold_w = rf_we;
    check("pre_stall", 64'(rf_wdata), 64'hCAFE_0001);
    w_stall = 1;
    for (int i = 0; i < 3; i++) begin
      m_alu = $urandom; m_wdst = 5'($urandom_range(1, 31));
      step();
      check("stall_data", 64'(rf_wdata), 64'(hold_d));
      check("stall_addr", 64'(rf_waddr), 64'(hold_a));
      check("stall_we", 64'(rf_we), 64'(hold_w));
    end
    w_flush = 1; step();
    check("sf_valid", 64'(w_valid), 64'd0);
    check("sf_we", 64'(rf_we), 64'd0);
    w_stall = 0; w_flush = 0;

    // Reset during a stall.
    instr(3'd0, 5'd3, 3'd0, 2'd0); step();
    w_stall = 1; reset = 0; step();
    check("rst_stall_valid", 64'(w_valid), 64'd0);
    check("rst_stall_pc", 64'(w_pc), 64'h3000);
    w_stall = 0; reset = 1;

`ifdef WB_RETIRE_CNT_EN
    reset = 0; step(); reset = 1;
    instr(3'd0, 5'd2, 3'd0, 2'd0);
    for (int i = 0; i < 10; i++) step();
    w_stall = 1; step(); step();
    w_stall = 0; w_flush = 1; step();
    w_flush = 0; m_valid = 0; step(); step();
    check("cnt10", 64'(retire_cnt), 64'd10);
    reset = 0; step(); reset = 1;
    m_valid = 1;
    for (int i = 0; i < 17; i++) step();
    m_valid = 0; step();
    check("cnt17", 64'(retire_cnt), 64'd17);
    check("cnt4_wrap", 64'(retire_cnt4), 64'd1);
`endif

    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 39) != 0);
      w_stall    = ($urandom_range(0, 4) == 0);
      w_flush    = ($urandom_range(0, 9) == 0);
      m_valid    = ($urandom_range(0, 5) != 0);
      m_wen      = ($urandom_range(0, 4) != 0);
      m_pc       = $urandom; m_alu = $urandom; m_mdu = $urandom; m_imm = $urandom;
      m_mem      = $urandom; m_cmp = $urandom;
      m_wsrc     = 3'($urandom_range(0, 7));
      m_load_op  = 3'($urandom_range(0, 7));
      m_boff     = 2'($urandom_range(0, 3));
      m_wdst     = 5'($urandom_range(0, 31));
      m_wdst_alt = 5'($urandom_range(0, 31));
      m_cond_dst = $urandom_range(0, 1) == 1;
      step();
      check_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
